gen_physical_regfile: RTL
=========================

GEN_PHYSICAL_REGFILE -- requirements
Module: gen_physical_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 64, register width in bits.
REQ-002 SHALL have parameter REG_SIZE, default 36, number of physical registers.
REQ-003 SHALL have parameter REG_SIZE_WIDTH, default 6, address width, at least clog2(REG_SIZE).
REQ-004 SHALL have parameter RD_PORTS, default 6, number of combinational read ports.
REQ-005 SHALL have parameter WB_PORTS, default 4, number of writeback requesters.
REQ-006 SHALL have parameter WR_LANES, default 2, maximum register-array writes per cycle, 1..WB_PORTS.
REQ-007 SHALL have parameter ZERO_REG, default 1; when 1, P0 is hardwired to zero.
REQ-008 SHALL have port clk, input, 1, the single clock; one clock, all state on rising edge.
REQ-009 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-010 SHALL have port rd_addr_i, input, RD_PORTS*REG_SIZE_WIDTH, packed read addresses, port k at slice k.
REQ-011 SHALL have port rd_data_o, output, RD_PORTS*DATA_W, packed read data.
REQ-012 SHALL have port wb_valid_i, input, WB_PORTS, writeback request per requester.
REQ-013 SHALL have port wb_ready_o, output, WB_PORTS, writeback accepted this cycle.
REQ-014 SHALL have port wb_addr_i, input, WB_PORTS*REG_SIZE_WIDTH, writeback addresses.
REQ-015 SHALL have port wb_data_i, input, WB_PORTS*DATA_W, writeback data.
REQ-016 SHALL have port stall_cnt_o, output, 32, saturating count of cycles with at least one refused valid request.

Function
REQ-017 SHALL accept a write on requester k, a "handshake", iff wb_valid_i[k] and wb_ready_o[k] are both high in the same cycle; the register commits at that rising edge.
REQ-018 SHALL require each requester to hold valid, addr and data stable until accepted; wb_ready_o SHALL be combinational from wb_valid_i and the round-robin pointer.
REQ-019 SHALL grant at most WR_LANES array-writing requests per cycle, scanning ports from rr_ptr upward modulo WB_PORTS.
REQ-020 SHALL, when ZERO_REG=1, always ready a valid write to address 0, discard its data and not count it against WR_LANES.
REQ-021 SHALL update rr_ptr after a cycle with any lane-consuming grant to (last granted port in scan order + 1) mod WB_PORTS; otherwise rr_ptr SHALL hold.
REQ-022 SHALL, when two same-cycle grants target one address, commit the data of the higher port index.
REQ-023 SHALL drive rd_data_o combinationally, with zero read latency.
REQ-024 SHALL forward: if a read address equals an address granted this cycle, return that write data (per REQ-022 on collision); otherwise return the array content.
REQ-025 SHALL, when ZERO_REG=1, read address 0 as all-zeros.
REQ-026 SHALL, for read addresses >= REG_SIZE, return zero; writes to them SHALL be accepted and dropped.
REQ-027 SHALL increment stall_cnt_o by 1 in any cycle where some wb_valid_i[k] is high with wb_ready_o[k] low, saturating at 0xFFFFFFFF.
REQ-028 SHALL make no requester wait more than ceil(WB_PORTS/WR_LANES) cycles after raising valid.

Reset
REQ-029 SHALL, while rst is low, asynchronously clear all registers, rr_ptr and stall_cnt_o to 0.
REQ-030 SHALL, on rst low mid-cycle, discard the same-cycle handshake with no commit; on rst release, the first edge SHALL behave as from idle.

Configuration
REQ-031 SHALL, with PRF_DEBUG_PORT_EN defined, add inputs dbg_addr0_i/dbg_addr1_i (REG_SIZE_WIDTH) and outputs dbg_data0_o/dbg_data1_o (DATA_W) returning raw array contents, no forwarding.
REQ-032 SHALL, without PRF_DEBUG_PORT_EN, omit these ports; all other behaviour SHALL be identical.

Verification
REQ-033 SHALL cover: after reset, all 4 valid to P5..P8 with data 0x11..0x44 -> cycle 1 ready=0011; cycle 2 ready=1100; P5..P8 hold 0x11..0x44; stall_cnt_o=1.
REQ-034 SHALL cover: port0 writes 0xDEAD to P3 while rd_addr port2=3 -> rd_data port2=0xDEAD in that cycle, and from the array next cycle.
REQ-035 SHALL cover: ports 1 and 3 granted to P7 with 0xA and 0xB -> forwarded read and committed P7 both =0xB.
REQ-036 SHALL cover: ZERO_REG=1, ports 0,1,2 valid, port0 addr 0 -> all three ready in one cycle; P0 reads 0.
REQ-037 SHALL cover: rst asserted low between edges during a handshake to P9 -> P9=0, rr_ptr=0, stall_cnt_o=0.
REQ-038 SHALL cover: requester 2 held valid while others continuously request -> accepted within 2 cycles with default parameters.

Source files
------------

// File: rtl/gen_physical_regfile.sv
// ============================================================================
// Module      : gen_physical_regfile
// Description : Physical register file with RD_PORTS combinational read ports
//               and WB_PORTS valid/ready writeback requesters arbitrated
//               round-robin onto WR_LANES array write lanes per cycle.
//               Same-cycle writes are forwarded to the read ports. A
//               saturating counter records cycles in which any request was
//               refused.
//               Optional raw-array debug read ports: PRF_DEBUG_PORT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gen_physical_regfile #(
  parameter int DATA_W         = 64,
  parameter int REG_SIZE       = 36,
  parameter int REG_SIZE_WIDTH = 6,
  parameter int RD_PORTS       = 6,
  parameter int WB_PORTS       = 4,
  parameter int WR_LANES       = 2,
  parameter int ZERO_REG       = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [RD_PORTS*REG_SIZE_WIDTH-1:0] rd_addr_i,
  output logic [RD_PORTS*DATA_W-1:0]         rd_data_o,
  input  logic [WB_PORTS-1:0]                wb_valid_i,
  output logic [WB_PORTS-1:0]                wb_ready_o,
  input  logic [WB_PORTS*REG_SIZE_WIDTH-1:0] wb_addr_i,
  input  logic [WB_PORTS*DATA_W-1:0]         wb_data_i,
  output logic [31:0]                        stall_cnt_o
`ifdef PRF_DEBUG_PORT_EN
  ,
  input  logic [REG_SIZE_WIDTH-1:0]          dbg_addr0_i,
  input  logic [REG_SIZE_WIDTH-1:0]          dbg_addr1_i,
  output logic [DATA_W-1:0]                  dbg_data0_o,
  output logic [DATA_W-1:0]                  dbg_data1_o
`endif
);

  localparam int c_ptr_w = (WB_PORTS > 1) ? $clog2(WB_PORTS) : 1;
  // One extra bit so REG_SIZE itself is representable for the range compare.
  localparam logic [REG_SIZE_WIDTH:0] c_reg_lim = (REG_SIZE_WIDTH+1)'(REG_SIZE);

  logic [DATA_W-1:0]         r_regs [REG_SIZE];
  logic [c_ptr_w-1:0]        r_rr_ptr;
  logic [31:0]               r_stall_cnt;

  logic [REG_SIZE_WIDTH-1:0] w_wb_addr [WB_PORTS];
  logic [DATA_W-1:0]         w_wb_data [WB_PORTS];
  logic [WB_PORTS-1:0]       w_wb_zero;
  logic [WB_PORTS-1:0]       w_wb_inrange;
  logic [WB_PORTS-1:0]       w_ready;
  logic [WB_PORTS-1:0]       w_commit;
  logic                      w_lane_used;
  logic [c_ptr_w-1:0]        w_last;
  logic [c_ptr_w-1:0]        w_ptr_nxt;
  logic                      w_stall;

  // Per-requester slicing and address classification.
  generate
    for (genvar k = 0; k < WB_PORTS; k++) begin : g_wb
      assign w_wb_addr[k]    = wb_addr_i[k*REG_SIZE_WIDTH +: REG_SIZE_WIDTH];
      assign w_wb_data[k]    = wb_data_i[k*DATA_W +: DATA_W];
      assign w_wb_zero[k]    = (ZERO_REG != 0) && (w_wb_addr[k] == '0);
      assign w_wb_inrange[k] = ({1'b0, w_wb_addr[k]} < c_reg_lim);
      // Only granted, in-range, non-hardwired writes touch the array.
      assign w_commit[k]     = w_ready[k] & ~w_wb_zero[k] & w_wb_inrange[k];
    end
  endgenerate

  // Round-robin grant: walk a doubled index range so every port index is a
  // constant after unrolling; only the WB_PORTS-wide window at r_rr_ptr counts.
  // Writes to the hardwired zero register are readied without using a lane.
  always_comb begin : arb
    int lanes;
    int ptr;
    w_ready     = '0;
    w_lane_used = 1'b0;
    w_last      = '0;
    lanes       = 0;
    ptr         = int'(r_rr_ptr);
    for (int i = 0; i < 2*WB_PORTS; i++) begin
      if (i >= ptr && i < ptr + WB_PORTS && wb_valid_i[i % WB_PORTS]) begin
        if (w_wb_zero[i % WB_PORTS]) begin
          w_ready[i % WB_PORTS] = 1'b1;
        end else if (lanes < WR_LANES) begin
          w_ready[i % WB_PORTS] = 1'b1;
          lanes                 = lanes + 1;
          w_lane_used           = 1'b1;
          w_last                = c_ptr_w'(i % WB_PORTS);
        end
      end
    end
  end

  assign w_ptr_nxt   = (int'(w_last) == WB_PORTS-1) ? '0 : w_last + c_ptr_w'(1);
  assign w_stall     = |(wb_valid_i & ~w_ready);
  assign wb_ready_o  = w_ready;
  assign stall_cnt_o = r_stall_cnt;

  // Arbitration pointer and saturating refused-request cycle counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr    <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_lane_used) begin
        r_rr_ptr <= w_ptr_nxt;
      end
      if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  // Register array: ascending port order so the highest index wins a collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_SIZE; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int k = 0; k < WB_PORTS; k++) begin
        if (w_commit[k]) begin
          r_regs[w_wb_addr[k]] <= w_wb_data[k];
        end
      end
    end
  end

  // Combinational read ports with same-cycle write forwarding.
  generate
    for (genvar r = 0; r < RD_PORTS; r++) begin : g_rd
      logic [REG_SIZE_WIDTH-1:0] w_ra;
      logic [DATA_W-1:0]         w_rv;
      logic                      w_rd_ok;

      assign w_ra    = rd_addr_i[r*REG_SIZE_WIDTH +: REG_SIZE_WIDTH];
      assign w_rd_ok = ({1'b0, w_ra} < c_reg_lim) &&
                       !((ZERO_REG != 0) && (w_ra == '0));

      // Array value, overridden by granted writes in ascending port order.
      always_comb begin
        w_rv = '0;
        if (w_rd_ok) begin
          w_rv = r_regs[w_ra];
          for (int k = 0; k < WB_PORTS; k++) begin
            if (w_commit[k] && (w_wb_addr[k] == w_ra)) begin
              w_rv = w_wb_data[k];
            end
          end
        end
      end

      assign rd_data_o[r*DATA_W +: DATA_W] = w_rv;
    end
  endgenerate

`ifdef PRF_DEBUG_PORT_EN
  // Raw array peek; no forwarding, out-of-range reads as zero.
  assign dbg_data0_o = ({1'b0, dbg_addr0_i} < c_reg_lim) ? r_regs[dbg_addr0_i] : '0;
  assign dbg_data1_o = ({1'b0, dbg_addr1_i} < c_reg_lim) ? r_regs[dbg_addr1_i] : '0;
`else
  // Debug peek ports are not present in this build.
`endif

endmodule

`default_nettype wire
